sdrc_burst_master: RTL and testbench

SDRC_BURST_MASTER -- requirements
Module: sdrc_burst_master

---
 rtl/sdrc_burst_master.sv | 174 +++++++++++++++++
 tb/tb_sdrc_burst_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_burst_master.sv
// Burst master in front of an SDRAM controller core: queues write data in a
// show-ahead FIFO, issues one app_req per command and streams the burst data.
module sdrc_burst_master #(
    parameter int unsigned DW       = 32,
    parameter int unsigned WD_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [29:0]     cmd_addr,
    input  logic [8:0]      cmd_len,
    input  logic            cmd_wr_n,
    input  logic            wd_valid,
    output logic            wd_ready,
    input  logic [DW-1:0]   wd_data,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            rd_last,
    output logic            err,
    output logic            app_req,
    output logic [29:0]     app_req_addr,
    output logic [8:0]      app_req_len,
    output logic            app_req_wr_n,
    input  logic            app_req_ack,
    input  logic            app_wr_next_req,
    output logic [DW-1:0]   app_wr_data,
    output logic [DW/8-1:0] app_wr_en_n,
    input  logic            app_rd_valid,
    input  logic [DW-1:0]   app_rd_data
);

    localparam int unsigned AW  = $clog2(WD_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BEW = DW / 8;

    typedef enum logic [2:0] {IDLE, WAIT_WD, REQ, WDATA, RDATA} state_t;

    state_t        state;
    logic [DW-1:0] mem [WD_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [8:0]    pop_cnt;
    logic [8:0]    beat_cnt;
    logic          push_c;
    logic          pop_c;
    logic          last_pop_c;
    logic          last_beat_c;

    // FIFO handshakes and the final pop/beat of the current burst
    always_comb begin
        push_c      = wd_valid && wd_ready;
        pop_c       = (state == WDATA) && app_wr_next_req && (count != '0);
        last_pop_c  = pop_c && (pop_cnt == app_req_len - 9'd1);
        last_beat_c = (state == RDATA) && app_rd_valid && (beat_cnt == app_req_len - 9'd1);
        count_nxt   = count;
        if (push_c && !pop_c) begin
            count_nxt = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wd_data;
        end
    end

    assign app_wr_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            wd_ready     <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pop_cnt      <= '0;
            beat_cnt     <= '0;
            err          <= 1'b0;
            app_req      <= 1'b0;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b0;
            app_wr_en_n  <= '1;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_data      <= '0;
        end else begin
            count    <= count_nxt;
            wd_ready <= (count_nxt < CW'(WD_DEPTH));
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            rd_valid <= (state == RDATA) && app_rd_valid;
            rd_data  <= app_rd_data;
            rd_last  <= last_beat_c;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        app_req_addr <= cmd_addr;
                        app_req_len  <= cmd_len;
                        app_req_wr_n <= cmd_wr_n;
                        pop_cnt      <= '0;
                        beat_cnt     <= '0;
                        // Zero-length and oversized writes complete without leaving IDLE
                        if (cmd_len == 9'd0) begin
                            state <= IDLE;
                        end else if (!cmd_wr_n && (cmd_len > 9'(WD_DEPTH))) begin
                            err <= 1'b1;
                        end else if (!cmd_wr_n) begin
                            state     <= WAIT_WD;
                            cmd_ready <= 1'b0;
                        end else begin
                            state     <= REQ;
                            app_req   <= 1'b1;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                WAIT_WD: begin
                    if (9'(count) >= app_req_len) begin
                        state   <= REQ;
                        app_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (app_req_ack) begin
                        app_req <= 1'b0;
                        if (app_req_wr_n) begin
                            state <= RDATA;
                        end else begin
                            state       <= WDATA;
                            app_wr_en_n <= '0;
                        end
                    end
                end
                WDATA: begin
                    if (pop_c) begin
                        pop_cnt <= pop_cnt + 9'd1;
                    end
                    if (last_pop_c) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        app_wr_en_n <= BEW'({BEW{1'b1}});
                    end
                end
                RDATA: begin
                    if (app_rd_valid) begin
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                    if (last_beat_c) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_burst_master.sv
// Directed bench for sdrc_burst_master with a transaction-level reference
// model checked every cycle plus literal checks on the burst contents.
module tb_sdrc_burst_master;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int P_IDLE = 0, P_WAIT = 1, P_REQ = 2, P_WR = 3, P_RD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_wr_n;
    logic [29:0]   cmd_addr;
    logic [8:0]    cmd_len;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid, rd_last, err;
    logic [DW-1:0] rd_data;
    logic          app_req, app_req_wr_n, app_req_ack, app_wr_next_req;
    logic [29:0]   app_req_addr;
    logic [8:0]    app_req_len;
    logic [DW-1:0] app_wr_data;
    logic [3:0]    app_wr_en_n;
    logic          app_rd_valid;
    logic [DW-1:0] app_rd_data;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sdrc_burst_master #(.DW(DW), .WD_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_wr_n(cmd_wr_n),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .err(err),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
        .app_wr_next_req(app_wr_next_req), .app_wr_data(app_wr_data),
        .app_wr_en_n(app_wr_en_n), .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, burst progress as words done versus length
    logic [DW-1:0] m_q[$];
    bit            m_err;
    int            m_phase;
    logic [29:0]   m_addr;
    logic [8:0]    m_len;
    logic          m_wrn;
    int            m_done;
    bit            e_rd_valid, e_rd_last;
    logic [DW-1:0] e_rd_data;
    int            sz;
    bit            m_push, m_pop;

    always @(posedge clk) begin
        sz = m_q.size();
        if (reset) begin
            m_q.delete();
            m_err = 0; m_phase = P_IDLE; m_addr = '0; m_len = '0; m_wrn = 1'b0;
            m_done = 0; e_rd_valid = 0; e_rd_last = 0;
        end else begin
            m_push     = wd_valid && (sz < DEPTH);
            m_pop      = (m_phase == P_WR) && app_wr_next_req && (sz > 0);
            e_rd_valid = (m_phase == P_RD) && app_rd_valid;
            e_rd_data  = app_rd_data;
            e_rd_last  = e_rd_valid && (m_done + 1 == int'(m_len));
            case (m_phase)
                P_IDLE: if (cmd_valid) begin
                    m_addr = cmd_addr; m_len = cmd_len; m_wrn = cmd_wr_n; m_done = 0;
                    if (int'(cmd_len) == 0) m_phase = P_IDLE;
                    else if (!cmd_wr_n && int'(cmd_len) > DEPTH) m_err = 1;
                    else m_phase = cmd_wr_n ? P_REQ : P_WAIT;
                end
                P_WAIT: if (sz >= int'(m_len)) m_phase = P_REQ;
                P_REQ:  if (app_req_ack) m_phase = m_wrn ? P_RD : P_WR;
                P_WR: if (m_pop) begin
                    m_done++;
                    if (m_done == int'(m_len)) m_phase = P_IDLE;
                end
                P_RD: if (app_rd_valid) begin
                    m_done++;
                    if (m_done == int'(m_len)) m_phase = P_IDLE;
                end
                default: m_phase = P_IDLE;
            endcase
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back(wd_data);
        end
        #1;
        chk("cmd_ready", 64'(cmd_ready), 64'(m_phase == P_IDLE));
        chk("app_req", 64'(app_req), 64'(m_phase == P_REQ));
        chk("app_wr_en_n", 64'(app_wr_en_n), 64'((m_phase == P_WR) ? 4'h0 : 4'hF));
        chk("wd_ready", 64'(wd_ready), 64'(m_q.size() < DEPTH));
        chk("err", 64'(err), 64'(m_err));
        chk("rd_valid", 64'(rd_valid), 64'(e_rd_valid));
        chk("rd_last", 64'(rd_last), 64'(e_rd_last));
        chk("app_req_addr", 64'(app_req_addr), 64'(m_addr));
        chk("app_req_len", 64'(app_req_len), 64'(m_len));
        chk("app_req_wr_n", 64'(app_req_wr_n), 64'(m_wrn));
        if (e_rd_valid) chk("rd_data", 64'(rd_data), 64'(e_rd_data));
        if (m_q.size() > 0) chk("app_wr_data", 64'(app_wr_data), 64'(m_q[0]));
    end

    // Record what actually left the DUT, for the literal checks
    logic [DW-1:0] popped[$];
    logic [DW-1:0] rd_seen[$];
    int            last_idx[$];

    always @(negedge clk) begin
        #1;
        if (!reset && app_wr_next_req && app_wr_en_n == 4'h0) popped.push_back(app_wr_data);
        if (rd_valid) begin
            rd_seen.push_back(rd_data);
            if (rd_last) last_idx.push_back(rd_seen.size());
        end
    end

    task automatic push1(input logic [DW-1:0] d);
        wd_valid = 1'b1; wd_data = d;
        @(negedge clk);
        wd_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [29:0] a, input logic [8:0] l, input logic wrn);
        for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_wr_n = wrn;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req_ack(input string name);
        for (int k = 0; k < 50 && !app_req; k++) @(negedge clk);
        chk(name, 64'(app_req), 64'(1));
        app_req_ack = 1'b1;
        @(negedge clk);
        app_req_ack = 1'b0;
    endtask

    task automatic do_pops(input string name, input int n);
        int got = 0;
        for (int k = 0; k < 200 && got < n; k++) begin
            app_wr_next_req = (k % 3 != 1);
            if (app_wr_next_req && app_wr_en_n == 4'h0) got++;
            @(negedge clk);
        end
        app_wr_next_req = 1'b0;
        chk(name, 64'(got), 64'(n));
    endtask

    task automatic do_beats(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            app_rd_valid = 1'b1; app_rd_data = base + DW'(i);
            @(negedge clk);
            app_rd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    logic [DW-1:0] wr_words [5] = '{32'h11223344, 32'h22334455, 32'h33445566,
                                    32'h44556677, 32'h55667788};

    initial begin
        reset = 1'b1; cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_wr_n = 0;
        wd_valid = 0; wd_data = '0; app_req_ack = 0; app_wr_next_req = 0;
        app_rd_valid = 0; app_rd_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_wd_ready", 64'(wd_ready), 64'(1));
        chk("rst_wr_en_n", 64'(app_wr_en_n), 64'(4'hF));
        chk("rst_app_req", 64'(app_req), 64'(0));
        chk("rst_err", 64'(err), 64'(0));

        // Queued write burst of five words
        for (int i = 0; i < 5; i++) push1(wr_words[i]);
        send_cmd(30'h10000, 9'd5, 1'b0);
        wait_req_ack("wr_req_seen");
        chk("wr_addr", 64'(app_req_addr), 64'(30'h10000));
        do_pops("wr_pops", 5);
        chk("wr_done_idle", 64'(cmd_ready), 64'(1));
        chk("wr_pop_count", 64'(popped.size()), 64'(5));
        for (int i = 0; i < 5 && i < popped.size(); i++)
            chk("wr_pop_data", 64'(popped[i]), 64'(wr_words[i]));

        // app_wr_next_req in IDLE must not pop
        push1(32'hDEADBEEF);
        app_wr_next_req = 1'b1;
        repeat (2) @(negedge clk);
        app_wr_next_req = 1'b0;
        chk("idle_no_pop", 64'(app_wr_data), 64'(32'hDEADBEEF));

        // Read burst; a beat during REQ is ignored
        rd_seen.delete(); last_idx.delete();
        send_cmd(30'h10000, 9'd5, 1'b1);
        for (int k = 0; k < 50 && !app_req; k++) @(negedge clk);
        app_rd_valid = 1'b1; app_rd_data = 32'hBADBAD00;
        @(negedge clk);
        app_rd_valid = 1'b0;
        wait_req_ack("rd_req_seen");
        do_beats(5, 32'hA0000000);
        repeat (2) @(negedge clk);
        chk("rd_beat_count", 64'(rd_seen.size()), 64'(5));
        for (int i = 0; i < 5 && i < rd_seen.size(); i++)
            chk("rd_beat_data", 64'(rd_seen[i]), 64'(32'hA0000000 + i));
        chk("rd_last_count", 64'(last_idx.size()), 64'(1));
        if (last_idx.size() > 0) chk("rd_last_pos", 64'(last_idx[0]), 64'(5));

        // Write issued with three words queued waits for the fifth push
        popped.delete();
        push1(32'h0A0A0001);
        push1(32'h0A0A0002);
        send_cmd(30'h00123, 9'd5, 1'b0);
        repeat (4) @(negedge clk);
        chk("early_req", 64'(app_req), 64'(0));
        push1(32'h0A0A0003);
        wd_valid = 1'b1; wd_data = 32'h0A0A0004;
        @(negedge clk);
        wd_valid = 1'b0;
        chk("req_at_5th_push", 64'(app_req), 64'(0));
        @(negedge clk);
        chk("req_after_5th_push", 64'(app_req), 64'(1));
        wait_req_ack("late_req_seen");
        do_pops("late_pops", 5);
        chk("late_pop_count", 64'(popped.size()), 64'(5));
        if (popped.size() == 5) begin
            chk("late_pop_first", 64'(popped[0]), 64'(32'hDEADBEEF));
            chk("late_pop_last", 64'(popped[4]), 64'(32'h0A0A0004));
        end

        // Full FIFO, oversized write, simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push1(32'hF0000000 + DW'(i));
        chk("full_wd_ready", 64'(wd_ready), 64'(0));
        send_cmd(30'h0, 9'd17, 1'b0);
        chk("err_set", 64'(err), 64'(1));
        repeat (3) @(negedge clk);
        chk("no_req_len17", 64'(app_req), 64'(0));
        send_cmd(30'h20, 9'd16, 1'b0);
        wait_req_ack("full_req_seen");
        app_wr_next_req = 1'b1;
        @(negedge clk);
        chk("one_popped_ready", 64'(wd_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            wd_valid = 1'b1; wd_data = 32'hE0000000 + DW'(i);
            @(negedge clk);
            chk("push_pop_ready", 64'(wd_ready), 64'(1));
        end
        wd_valid = 1'b0; app_wr_next_req = 1'b0;
        do_pops("full_pops", 12);
        chk("full_done_idle", 64'(cmd_ready), 64'(1));
        chk("leftover_head", 64'(app_wr_data), 64'(32'hE0000000));
        chk("err_sticky", 64'(err), 64'(1));

        // Zero-length read, then reset in the middle of a read burst
        send_cmd(30'h55, 9'd0, 1'b1);
        repeat (3) @(negedge clk);
        chk("len0_no_req", 64'(app_req), 64'(0));
        chk("len0_idle", 64'(cmd_ready), 64'(1));
        rd_seen.delete();
        send_cmd(30'h10000, 9'd4, 1'b1);
        wait_req_ack("rst_rd_req_seen");
        do_beats(1, 32'hC0000000);
        app_rd_valid = 1'b1; app_rd_data = 32'hC0000001; reset = 1'b1;
        @(negedge clk);
        app_rd_valid = 1'b0;
        chk("midrst_rd_valid", 64'(rd_valid), 64'(0));
        chk("midrst_app_req", 64'(app_req), 64'(0));
        chk("midrst_err", 64'(err), 64'(0));
        chk("midrst_wd_ready", 64'(wd_ready), 64'(1));
        chk("midrst_wr_en_n", 64'(app_wr_en_n), 64'(4'hF));
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        do_beats(2, 32'hC0000010);
        chk("midrst_beats", 64'(rd_seen.size()), 64'(1));
        push1(32'h12345678);
        chk("flush_head", 64'(app_wr_data), 64'(32'h12345678));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end

endmodule
